czstkctl: RTL and testbench
===========================

CZSTKCTL -- requirements
Module: czstkctl

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 10, which sets the return-address width.
REQ-002 The block SHALL have parameter STACK_WIDTH, default 4, the stack RAM address width, giving RAM depth D = 2**STACK_WIDTH.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 PUSH  in  1  push request (call).
REQ-006 POP  in  1  pop request (return).
REQ-007 PDI  in  PC_WIDTH  address to push.
REQ-008 FLUSH  in  1  synchronous empty-stack command.
REQ-009 ERRCLR  in  1  synchronous clear of the sticky error flags.
REQ-010 TOS  out  PC_WIDTH  top-of-stack register (return address).
REQ-011 READY  out  1  request acceptance; 0 during the refill cycle.
REQ-012 EMPTY / FULL  out  1 each  depth==0 / depth==D+1.
REQ-013 DEPTH  out  STACK_WIDTH+1  entry count, 0..D+1.
REQ-014 OVF / UNF  out  1 each  sticky overflow / underflow flags.
REQ-015 SMEMA  out  STACK_WIDTH  stack RAM address.
REQ-016 SMEMWE  out  1  stack RAM write enable.
REQ-017 SMEMDI  out  PC_WIDTH  stack RAM write data.
REQ-018 SMEMDO  in  PC_WIDTH  stack RAM read data, registered, valid the cycle after the address is presented, with read-before-write.

Function
REQ-019 TOS SHALL hold the top entry; the RAM SHALL hold entries below it, so capacity = D+1 and the RAM occupancy is M = DEPTH-1 when DEPTH>0.
REQ-020 The FSM SHALL have states IDLE (READY=1) and FILL (READY=0).
REQ-021 A PUSH alone in IDLE with DEPTH==0: TOS<=PDI, DEPTH<=1, SMEMWE=0.
REQ-022 A PUSH alone in IDLE with 0<DEPTH<D+1: SMEMA=M, SMEMWE=1, SMEMDI=TOS in the same cycle; TOS<=PDI, DEPTH++.
REQ-023 A POP alone in IDLE with DEPTH==1: DEPTH<=0, TOS unchanged, no RAM access.
REQ-024 A POP alone in IDLE with DEPTH>=2: SMEMA=M-1, SMEMWE=0 in the same cycle; DEPTH--; next state FILL.
REQ-025 FILL SHALL last exactly one cycle: TOS<=SMEMDO, then return to IDLE, so there is 1 refill cycle per multi-entry pop.
REQ-026 During FILL, PUSH, POP and FLUSH SHALL be ignored without flagging, and the requester SHALL hold its request until READY=1.
REQ-027 PUSH and POP together in IDLE with DEPTH>=1 SHALL replace TOS with PDI, leave DEPTH unchanged, and make no RAM access.
REQ-028 PUSH and POP together with DEPTH==0 SHALL behave as a PUSH alone.
REQ-029 A PUSH alone with FULL SHALL be ignored and SHALL set OVF.
REQ-030 A POP alone with EMPTY SHALL be ignored and SHALL set UNF.
REQ-031 FLUSH in IDLE SHALL set DEPTH<=0 and SHALL override PUSH/POP that cycle; TOS and the RAM are left unchanged.
REQ-032 ERRCLR SHALL clear OVF and UNF; a same-cycle set SHALL win over the clear.
REQ-033 SMEMA, SMEMWE and SMEMDI SHALL be combinational from the state, DEPTH, PUSH and POP.
REQ-034 When no access is made: SMEMWE=0, SMEMA=0, SMEMDI=0.
REQ-035 DEPTH arithmetic SHALL never wrap; EMPTY and FULL SHALL be decoded from DEPTH.

Reset
REQ-036 RST SHALL asynchronously force: state IDLE, DEPTH=0, TOS=0, OVF=0, UNF=0, giving READY=1, EMPTY=1, FULL=0, SMEMWE=0.
REQ-037 RST asserted during FILL SHALL abort the refill; the RAM contents are don't-care after reset.

Structure
REQ-038 PC_WIDTH, STACK_WIDTH and the FSM state encodings SHALL live in the shared header czdefs.vh.
REQ-039 The block SHALL have no sub-module; the stack RAM is instantiated beside it by the parent and wired through the SMEM* ports.

Verification (bench: STACK_WIDTH=2, D=4, capacity 5; bench RAM model with 1-cycle registered read)
REQ-040 Push 0x011,0x022,0x033 on consecutive cycles -> DEPTH=3, TOS=0x033, RAM[0]=0x011, RAM[1]=0x022.
REQ-041 From REQ-040, POP -> SMEMA=1 in the pop cycle, READY=0 for 1 cycle, then TOS=0x022, DEPTH=2; POP is ignored while READY=0.
REQ-042 Push 6 entries -> FULL after the 5th push; the 6th push sets OVF=1, and TOS and DEPTH stay at the 5th push's value.
REQ-043 POP on EMPTY -> UNF=1, DEPTH=0; then ERRCLR -> UNF=0; UNF set and ERRCLR in the same cycle -> UNF=1.
REQ-044 PUSH+POP at DEPTH=2 with PDI=0x3FF -> TOS=0x3FF, DEPTH=2, SMEMWE=0.
REQ-045 RST asserted during FILL -> DEPTH=0, TOS=0, READY=1 immediately; FLUSH at DEPTH=3 -> EMPTY=1 next cycle.

Source files
------------

// File: rtl/czstkctl_pkg.sv
// Shared definitions for the call/return stack controller: default widths and FSM state encoding.
package czstkctl_pkg;

   localparam int unsigned PcWidthDef    = 10;
   localparam int unsigned StackWidthDef = 4;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StFill = 1'b1
   } ctlState;

endpackage

// File: rtl/czstkctl.sv
// Return-address stack controller: TOS held in a register, deeper entries in an external
// single-port RAM with registered read; one refill cycle follows each multi-entry pop.
module czstkctl
   import czstkctl_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = PcWidthDef,
   parameter int unsigned STACK_WIDTH = StackWidthDef
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   PUSH,
   input  logic                   POP,
   input  logic [PC_WIDTH-1:0]    PDI,
   input  logic                   FLUSH,
   input  logic                   ERRCLR,
   output logic [PC_WIDTH-1:0]    TOS,
   output logic                   READY,
   output logic                   EMPTY,
   output logic                   FULL,
   output logic [STACK_WIDTH:0]   DEPTH,
   output logic                   OVF,
   output logic                   UNF,
   output logic [STACK_WIDTH-1:0] SMEMA,
   output logic                   SMEMWE,
   output logic [PC_WIDTH-1:0]    SMEMDI,
   input  logic [PC_WIDTH-1:0]    SMEMDO
);

   localparam logic [STACK_WIDTH:0]   CapDepth = (STACK_WIDTH+1)'((1 << STACK_WIDTH) + 1);
   localparam logic [STACK_WIDTH:0]   OneDepth = (STACK_WIDTH+1)'(1);
   localparam logic [STACK_WIDTH-1:0] OneAddr  = STACK_WIDTH'(1);

   ctlState                 state;
   logic                    idle;
   logic                    doPush;
   logic                    doReplace;
   logic                    doPop;
   logic                    ovfSet;
   logic                    unfSet;
   logic [STACK_WIDTH:0]    depthM1;
   logic [STACK_WIDTH-1:0]  ramTop;

   assign READY   = (state == StIdle);
   assign EMPTY   = (DEPTH == '0);
   assign FULL    = (DEPTH == CapDepth);
   assign depthM1 = DEPTH - OneDepth;
   // RAM occupancy M = DEPTH-1 doubles as the next free RAM slot.
   assign ramTop  = depthM1[STACK_WIDTH-1:0];

   always_comb begin
      idle      = (state == StIdle);
      doPush    = idle & ~FLUSH & PUSH & (~POP | EMPTY);
      doReplace = idle & ~FLUSH & PUSH & POP & ~EMPTY;
      doPop     = idle & ~FLUSH & POP & ~PUSH;
      ovfSet    = doPush & FULL;
      unfSet    = doPop & EMPTY;

      SMEMWE = 1'b0;
      SMEMA  = '0;
      SMEMDI = '0;
      if (doPush && !EMPTY && !FULL) begin
         // Spill the current TOS beneath the new entry.
         SMEMWE = 1'b1;
         SMEMA  = ramTop;
         SMEMDI = TOS;
      end else if (doPop && (DEPTH > OneDepth)) begin
         SMEMA = ramTop - OneAddr;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= StIdle;
         DEPTH <= '0;
         TOS   <= '0;
         OVF   <= 1'b0;
         UNF   <= 1'b0;
      end else begin
         OVF <= ovfSet | (OVF & ~ERRCLR);
         UNF <= unfSet | (UNF & ~ERRCLR);
         unique case (state)
            StIdle: begin
               if (FLUSH) begin
                  DEPTH <= '0;
               end else if (doPush) begin
                  if (!FULL) begin
                     TOS   <= PDI;
                     DEPTH <= DEPTH + OneDepth;
                  end
               end else if (doReplace) begin
                  TOS <= PDI;
               end else if (doPop && !EMPTY) begin
                  DEPTH <= DEPTH - OneDepth;
                  if (DEPTH > OneDepth) state <= StFill;
               end
            end
            StFill: begin
               TOS   <= SMEMDO;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_czstkctl.sv
// Self-checking bench for czstkctl: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based stack model.
module tb_czstkctl;

   localparam int unsigned PW = 10;
   localparam int unsigned SW = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          PUSH, POP, FLUSH, ERRCLR;
   logic [PW-1:0] PDI;
   logic [PW-1:0] TOS;
   logic          READY, EMPTY, FULL, OVF, UNF;
   logic [SW:0]   DEPTH;
   logic [SW-1:0] SMEMA;
   logic          SMEMWE;
   logic [PW-1:0] SMEMDI;
   logic [PW-1:0] SMEMDO;

   logic [PW-1:0] mem [0:3];

   int checks = 0;
   int errors = 0;

   czstkctl #(
      .PC_WIDTH    (PW),
      .STACK_WIDTH (SW)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .PUSH   (PUSH),
      .POP    (POP),
      .PDI    (PDI),
      .FLUSH  (FLUSH),
      .ERRCLR (ERRCLR),
      .TOS    (TOS),
      .READY  (READY),
      .EMPTY  (EMPTY),
      .FULL   (FULL),
      .DEPTH  (DEPTH),
      .OVF    (OVF),
      .UNF    (UNF),
      .SMEMA  (SMEMA),
      .SMEMWE (SMEMWE),
      .SMEMDI (SMEMDI),
      .SMEMDO (SMEMDO)
   );

   always #5 CLK = ~CLK;

   // Stack RAM: registered read, read-before-write.
   always @(posedge CLK) begin
      if (SMEMWE) mem[SMEMA] <= SMEMDI;
      SMEMDO <= mem[SMEMA];
   end

   typedef struct {
      logic [3:0]    ctl;    // push, pop, flush, errclr
      logic [PW-1:0] pdi;
      logic          expWe;
      logic [SW-1:0] expA;
      logic [PW-1:0] expDi;
      logic [SW:0]   expDepth;
      logic [PW-1:0] expTos;
      logic [2:0]    flags;  // ready, ovf, unf
   } vec_t;

   vec_t vecs [23];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [PW-1:0] pdi,
                               input logic we, input logic [SW-1:0] a, input logic [PW-1:0] di,
                               input logic [SW:0] d, input logic [PW-1:0] tos,
                               input logic [2:0] flags);
      vec_t v;
      v.ctl = ctl; v.pdi = pdi; v.expWe = we; v.expA = a; v.expDi = di;
      v.expDepth = d; v.expTos = tos; v.flags = flags;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [PW-1:0] pdi);
      {PUSH, POP, FLUSH, ERRCLR} = ctl;
      PDI = pdi;
   endtask

   task automatic step(input logic [3:0] ctl, input logic [PW-1:0] pdi);
      drive(ctl, pdi);
      @(posedge CLK);
      #1;
   endtask

   task automatic chkRegs(input string tag, input logic [SW:0] d, input logic [PW-1:0] tos,
                          input logic rdy, input logic ovf, input logic unf);
      chk({tag, " DEPTH"}, 32'(DEPTH), 32'(d));
      chk({tag, " TOS"},   32'(TOS),   32'(tos));
      chk({tag, " READY"}, 32'(READY), 32'(rdy));
      chk({tag, " OVF"},   32'(OVF),   32'(ovf));
      chk({tag, " UNF"},   32'(UNF),   32'(unf));
      chk({tag, " EMPTY"}, 32'(EMPTY), 32'(d == 0));
      chk({tag, " FULL"},  32'(FULL),  32'(d == 5));
   endtask

   // Reference model state for the random phase.
   int unsigned   q[$];
   logic [PW-1:0] mTos;
   bit            mFill, mOvf, mUnf;

   initial begin
      bit            p, o, f, e, ovfSet, unfSet, act, ew;
      logic [PW-1:0] d, edi;
      int unsigned   sz, ea;

      vecs[0]  = mk(4'b1000, 10'h011, 1'b0, 2'd0, 10'h000, 3'd1, 10'h011, 3'b100);
      vecs[1]  = mk(4'b1000, 10'h022, 1'b1, 2'd0, 10'h011, 3'd2, 10'h022, 3'b100);
      vecs[2]  = mk(4'b1000, 10'h033, 1'b1, 2'd1, 10'h022, 3'd3, 10'h033, 3'b100);
      vecs[3]  = mk(4'b0100, 10'h000, 1'b0, 2'd1, 10'h000, 3'd2, 10'h033, 3'b000);
      vecs[4]  = mk(4'b0100, 10'h000, 1'b0, 2'd0, 10'h000, 3'd2, 10'h022, 3'b100);
      vecs[5]  = mk(4'b1100, 10'h3FF, 1'b0, 2'd0, 10'h000, 3'd2, 10'h3FF, 3'b100);
      vecs[6]  = mk(4'b0100, 10'h000, 1'b0, 2'd0, 10'h000, 3'd1, 10'h3FF, 3'b000);
      vecs[7]  = mk(4'b0000, 10'h000, 1'b0, 2'd0, 10'h000, 3'd1, 10'h011, 3'b100);
      vecs[8]  = mk(4'b0100, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h011, 3'b100);
      vecs[9]  = mk(4'b0100, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h011, 3'b101);
      vecs[10] = mk(4'b0001, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h011, 3'b100);
      vecs[11] = mk(4'b0101, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h011, 3'b101);
      vecs[12] = mk(4'b0001, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h011, 3'b100);
      vecs[13] = mk(4'b1000, 10'h101, 1'b0, 2'd0, 10'h000, 3'd1, 10'h101, 3'b100);
      vecs[14] = mk(4'b1000, 10'h102, 1'b1, 2'd0, 10'h101, 3'd2, 10'h102, 3'b100);
      vecs[15] = mk(4'b1000, 10'h103, 1'b1, 2'd1, 10'h102, 3'd3, 10'h103, 3'b100);
      vecs[16] = mk(4'b1000, 10'h104, 1'b1, 2'd2, 10'h103, 3'd4, 10'h104, 3'b100);
      vecs[17] = mk(4'b1000, 10'h105, 1'b1, 2'd3, 10'h104, 3'd5, 10'h105, 3'b100);
      vecs[18] = mk(4'b1000, 10'h106, 1'b0, 2'd0, 10'h000, 3'd5, 10'h105, 3'b110);
      vecs[19] = mk(4'b0010, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h105, 3'b110);
      vecs[20] = mk(4'b1100, 10'h0AA, 1'b0, 2'd0, 10'h000, 3'd1, 10'h0AA, 3'b110);
      vecs[21] = mk(4'b1010, 10'h0BB, 1'b0, 2'd0, 10'h000, 3'd0, 10'h0AA, 3'b110);
      vecs[22] = mk(4'b0001, 10'h000, 1'b0, 2'd0, 10'h000, 3'd0, 10'h0AA, 3'b100);

      RST = 1'b1;
      drive(4'b0000, '0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      chk("reset SMEMWE", 32'(SMEMWE), 32'(0));
      chkRegs("reset", 3'd0, 10'h000, 1'b1, 1'b0, 1'b0);
      @(posedge CLK);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].ctl, vecs[i].pdi);
         @(negedge CLK);
         chk($sformatf("vec%0d SMEMWE", i), 32'(SMEMWE), 32'(vecs[i].expWe));
         chk($sformatf("vec%0d SMEMA", i),  32'(SMEMA),  32'(vecs[i].expA));
         chk($sformatf("vec%0d SMEMDI", i), 32'(SMEMDI), 32'(vecs[i].expDi));
         @(posedge CLK);
         #1;
         chkRegs($sformatf("vec%0d", i), vecs[i].expDepth, vecs[i].expTos,
                 vecs[i].flags[2], vecs[i].flags[1], vecs[i].flags[0]);
         if (i == 2) begin
            chk("ram[0] after 3 pushes", 32'(mem[0]), 32'h011);
            chk("ram[1] after 3 pushes", 32'(mem[1]), 32'h022);
         end
      end

      // Reset landing in the refill cycle aborts it at once.
      step(4'b1000, 10'h0C1);
      step(4'b1000, 10'h0C2);
      step(4'b1000, 10'h0C3);
      step(4'b0100, 10'h000);
      chk("fill READY", 32'(READY), 32'(0));
      #2 RST = 1'b1;
      #1;
      chkRegs("async reset in fill", 3'd0, 10'h000, 1'b1, 1'b0, 1'b0);
      chk("async reset SMEMWE", 32'(SMEMWE), 32'(0));
      @(negedge CLK);
      RST = 1'b0;
      drive(4'b0000, '0);
      @(posedge CLK);
      #1;
      step(4'b1000, 10'h0C1);
      step(4'b1000, 10'h0C2);
      step(4'b1000, 10'h0C3);
      chk("pre-flush DEPTH", 32'(DEPTH), 32'(3));
      drive(4'b0010, 10'h000);
      @(negedge CLK);
      chk("flush SMEMWE", 32'(SMEMWE), 32'(0));
      @(posedge CLK);
      #1;
      chkRegs("flush at 3", 3'd0, 10'h0C3, 1'b1, 1'b0, 1'b0);

      q.delete();
      mTos  = 10'h0C3;
      mFill = 1'b0;
      mOvf  = 1'b0;
      mUnf  = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         p = ($urandom_range(0, 99) < 45);
         o = ($urandom_range(0, 99) < 40);
         f = ($urandom_range(0, 99) < 3);
         e = ($urandom_range(0, 99) < 6);
         d = PW'($urandom_range(0, 1023));
         drive({p, o, f, e}, d);

         @(negedge CLK);
         sz  = q.size();
         act = !mFill && !f;
         ew  = 1'b0;
         ea  = 0;
         edi = '0;
         if (act && p && (!o || sz == 0) && sz >= 1 && sz <= 4) begin
            ew  = 1'b1;
            ea  = sz - 1;
            edi = mTos;
         end else if (act && o && !p && sz >= 2) begin
            ea = sz - 2;
         end
         chk("rand SMEMWE", 32'(SMEMWE), 32'(ew));
         chk("rand SMEMA",  32'(SMEMA),  ea);
         chk("rand SMEMDI", 32'(SMEMDI), 32'(edi));

         @(posedge CLK);
         ovfSet = 1'b0;
         unfSet = 1'b0;
         if (mFill) begin
            mTos  = PW'(q[$]);
            mFill = 1'b0;
         end else if (f) begin
            q.delete();
         end else if (p && (!o || sz == 0)) begin
            if (sz == 5) ovfSet = 1'b1;
            else begin
               q.push_back(32'(d));
               mTos = d;
            end
         end else if (p && o) begin
            q[$] = 32'(d);
            mTos = d;
         end else if (o) begin
            if (sz == 0) unfSet = 1'b1;
            else if (sz == 1) q.delete();
            else begin
               void'(q.pop_back());
               mFill = 1'b1;
            end
         end
         mOvf = ovfSet | (mOvf & !e);
         mUnf = unfSet | (mUnf & !e);
         #1;
         chkRegs("rand", (SW+1)'(q.size()), mTos, !mFill, mOvf, mUnf);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
